reg_file_operand_stage: RTL and testbench

- Upstream neighbour of the LC-3 ALU. Holds the eight 16-bit general registers R0–R7 and selects the ALU operands A (SR1) and B (SR2 or sign-extended imm5) from the current IR.
- Captures results written back from the CPU bus.
- Also owns the NZP condition-code register and the BEN (branch-enable) register, since both are loaded from the same bus writeback and IR fields.

---
 rtl/reg_file_operand_stage.sv | 98 +++++++++
 tb/tb_reg_file_operand_stage.sv | 129 ++++++++++++
 2 files changed

// File: rtl/reg_file_operand_stage.sv
// ============================================================================
// reg_file_operand_stage : LC-3 register file, ALU operand select, NZP and BEN
// Revision: 1.0
// ============================================================================
`default_nettype none

module reg_file_operand_stage #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [15:0]      IR,
  input  logic [WIDTH-1:0] Bus,
  input  logic             LD_REG,
  input  logic             LD_CC,
  input  logic             LD_BEN,
  input  logic             DRMUX,
  input  logic             SR1MUX,
  input  logic             SR2MUX,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] SR1_Out,
  output logic [2:0]       NZP,
  output logic             BEN
);

  logic [WIDTH-1:0] regs [NREGS];
  logic [2:0]       dr;
  logic [2:0]       sr1;
  logic [2:0]       sr2;
  logic [NREGS-1:0] write_en;
  logic [2:0]       cc_next;
  logic [WIDTH-1:0] imm5_sext;
  logic             ben_next;
  logic [2:0]       nzp_q;
  logic             ben_q;

  assign dr        = DRMUX  ? 3'b111 : IR[11:9];
  assign sr1       = SR1MUX ? IR[8:6] : IR[11:9];
  assign sr2       = IR[2:0];
  assign imm5_sext = {{(WIDTH-5){IR[4]}}, IR[4:0]};

  // One-hot write decode: exactly one register captures Bus per LD_REG edge.
  always_comb begin
    write_en = '0;
    if (LD_REG) begin
      write_en[dr] = 1'b1;
    end
  end

  generate
    for (genvar i = 0; i < NREGS; i++) begin : g_regs
      always_ff @(posedge Clk) begin
        if (!Reset) begin
          regs[i] <= '0;
        end else if (write_en[i]) begin
          regs[i] <= Bus;
        end
      end
    end
  endgenerate

  always_comb begin
    cc_next = 3'b001;
    if (Bus[WIDTH-1]) begin
      cc_next = 3'b100;
    end else if (Bus == '0) begin
      cc_next = 3'b010;
    end
  end

  // BEN deliberately uses the pre-edge NZP, even when LD_CC fires on the same edge.
  assign ben_next = (IR[11] & nzp_q[2]) | (IR[10] & nzp_q[1]) | (IR[9] & nzp_q[0]);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      nzp_q <= 3'b010;
      ben_q <= 1'b0;
    end else begin
      if (LD_CC) begin
        nzp_q <= cc_next;
      end
      if (LD_BEN) begin
        ben_q <= ben_next;
      end
    end
  end

  assign A       = regs[sr1];
  assign SR1_Out = regs[sr1];
  assign B       = SR2MUX ? imm5_sext : regs[sr2];
  assign NZP     = nzp_q;
  assign BEN     = ben_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_file_operand_stage.sv
// ============================================================================
// tb_reg_file_operand_stage : directed self-checking bench for the operand stage
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_reg_file_operand_stage;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] IR;
  logic [15:0] Bus;
  logic        LD_REG, LD_CC, LD_BEN, DRMUX, SR1MUX, SR2MUX;
  logic [15:0] A, B, SR1_Out;
  logic [2:0]  NZP;
  logic        BEN;

  int errors = 0;
  int checks = 0;

  reg_file_operand_stage #(.WIDTH(16), .NREGS(8)) dut (
    .Clk(Clk), .Reset(Reset), .IR(IR), .Bus(Bus),
    .LD_REG(LD_REG), .LD_CC(LD_CC), .LD_BEN(LD_BEN),
    .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
    .A(A), .B(B), .SR1_Out(SR1_Out), .NZP(NZP), .BEN(BEN)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
    LD_REG = 1'b0; LD_CC = 1'b0; LD_BEN = 1'b0; DRMUX = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b0; IR = 16'h1E00; Bus = 16'hFFFF;
    LD_REG = 1'b1; LD_CC = 1'b1; LD_BEN = 1'b1; DRMUX = 1'b0; SR1MUX = 1'b0; SR2MUX = 1'b0;
    tick();
    Reset = 1'b1;
    tick();
    checks++; if (A !== 16'h0000) begin errors++; $display("FAIL reset_r7_no_write: got %h want 0000", A); end
    IR = 16'h0000; #1;
    checks++; if (A !== 16'h0000 || B !== 16'h0000) begin errors++; $display("FAIL reset_ab: got A=%h B=%h want 0000", A, B); end
    checks++; if (NZP !== 3'b010) begin errors++; $display("FAIL reset_nzp: got %b want 010", NZP); end
    checks++; if (BEN !== 1'b0) begin errors++; $display("FAIL reset_ben: got %b want 0", BEN); end
  endtask

  task automatic test_writeback();
    IR = 16'h1E00; Bus = 16'hBEEF; LD_REG = 1'b1; LD_CC = 1'b1; SR1MUX = 1'b0; #1;
    checks++; if (A !== 16'h0000) begin errors++; $display("FAIL no_bypass: got %h want 0000", A); end
    tick();
    checks++; if (A !== 16'hBEEF || SR1_Out !== 16'hBEEF) begin errors++; $display("FAIL writeback_r7: got A=%h SR1_Out=%h want beef", A, SR1_Out); end
    checks++; if (NZP !== 3'b100) begin errors++; $display("FAIL cc_negative: got %b want 100", NZP); end
  endtask

  task automatic test_operand_select();
    IR = 16'h0400; Bus = 16'h0005; LD_REG = 1'b1; tick();
    IR = 16'h0600; Bus = 16'hFFFB; LD_REG = 1'b1; tick();
    IR = 16'h0083; SR1MUX = 1'b1; SR2MUX = 1'b0; #1;
    checks++; if (A !== 16'h0005) begin errors++; $display("FAIL sr1_r2: got %h want 0005", A); end
    checks++; if (B !== 16'hFFFB) begin errors++; $display("FAIL sr2_r3: got %h want fffb", B); end
    IR = 16'h0090; SR2MUX = 1'b1; #1;
    checks++; if (B !== 16'hFFF0) begin errors++; $display("FAIL imm5_neg: got %h want fff0", B); end
    IR = 16'h008F; #1;
    checks++; if (B !== 16'h000F) begin errors++; $display("FAIL imm5_pos: got %h want 000f", B); end
    SR2MUX = 1'b0; #1;
    checks++; if (B !== 16'hBEEF) begin errors++; $display("FAIL sr2_r7: got %h want beef", B); end
    SR1MUX = 1'b0;
  endtask

  task automatic test_drmux();
    IR = 16'h0000; Bus = 16'h3001; DRMUX = 1'b1; LD_REG = 1'b1; tick();
    IR = 16'h0000; #1;
    checks++; if (A !== 16'h0000) begin errors++; $display("FAIL drmux_r0_untouched: got %h want 0000", A); end
    IR = 16'h0E00; #1;
    checks++; if (A !== 16'h3001) begin errors++; $display("FAIL drmux_r7: got %h want 3001", A); end
  endtask

  task automatic test_ben();
    Bus = 16'h0001; LD_CC = 1'b1; tick();
    checks++; if (NZP !== 3'b001) begin errors++; $display("FAIL cc_positive_setup: got %b want 001", NZP); end
    IR = 16'h0400; Bus = 16'h0000; LD_BEN = 1'b1; LD_CC = 1'b1; tick();
    checks++; if (BEN !== 1'b0) begin errors++; $display("FAIL ben_old_nzp: got %b want 0", BEN); end
    checks++; if (NZP !== 3'b010) begin errors++; $display("FAIL cc_zero_same_edge: got %b want 010", NZP); end
    LD_BEN = 1'b1; tick();
    checks++; if (BEN !== 1'b1) begin errors++; $display("FAIL ben_z_match: got %b want 1", BEN); end
  endtask

  task automatic test_cc_and_hold();
    Bus = 16'h0000; LD_CC = 1'b1; tick();
    checks++; if (NZP !== 3'b010) begin errors++; $display("FAIL cc_zero: got %b want 010", NZP); end
    Bus = 16'h7FFF; LD_CC = 1'b1; tick();
    checks++; if (NZP !== 3'b001) begin errors++; $display("FAIL cc_max_pos: got %b want 001", NZP); end
    Bus = 16'h8000; LD_CC = 1'b1; tick();
    checks++; if (NZP !== 3'b100) begin errors++; $display("FAIL cc_min_neg: got %b want 100", NZP); end
    for (int k = 0; k < 3; k++) begin
      Bus = 16'h1234 + 16'(k); IR = 16'hFFFF; tick();
    end
    IR = 16'h0083; SR1MUX = 1'b1; SR2MUX = 1'b0; #1;
    checks++; if (A !== 16'h0005 || B !== 16'hFFFB) begin errors++; $display("FAIL hold_regs: got A=%h B=%h want 0005 fffb", A, B); end
    IR = 16'h01C0; #1;
    checks++; if (A !== 16'h3001) begin errors++; $display("FAIL hold_r7: got %h want 3001", A); end
    checks++; if (NZP !== 3'b100 || BEN !== 1'b1) begin errors++; $display("FAIL hold_flags: got NZP=%b BEN=%b want 100 1", NZP, BEN); end
  endtask

  task automatic test_reset_mid();
    IR = 16'h0400; Bus = 16'h1234; LD_REG = 1'b1; LD_CC = 1'b1; LD_BEN = 1'b1; Reset = 1'b0; tick();
    Reset = 1'b1; IR = 16'h0080; SR1MUX = 1'b1; #1;
    checks++; if (A !== 16'h0000) begin errors++; $display("FAIL reset_mid_discard: got %h want 0000", A); end
    checks++; if (NZP !== 3'b010 || BEN !== 1'b0) begin errors++; $display("FAIL reset_mid_flags: got NZP=%b BEN=%b want 010 0", NZP, BEN); end
  endtask

  initial begin
    test_reset();
    test_writeback();
    test_operand_select();
    test_drmux();
    test_ben();
    test_cc_and_hold();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
